// File: rtl/cordic_lut_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : cordic_lut_pkg                                                   |
// | Purpose  : Shared types/constants for the CORDIC shift/scale ROM sequencer. |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package cordic_lut_pkg;

  localparam int LUT_P = 32;
  localparam int LUT_D = 5;

  // Reference single-precision ROM words at well-known iterations
  localparam logic [31:0] LUT_W_IDX0  = 32'h3F7F0000;
  localparam logic [31:0] LUT_W_IDX7  = 32'h3F000000;
  localparam logic [31:0] LUT_W_IDX31 = 32'h35FFFFB4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/lut_shift_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : lut_shift_sequencer                                              |
// | Purpose  : Walks the CORDIC shift/scale ROM and hands each word, with its   |
// |            iteration index, to the datapath over valid/ready.               |
// |            Optional macro LUT_SEQ_PREFETCH_EN: overlap next ROM read with   |
// |            the HOLD phase for two-cycle steps.                              |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module lut_shift_sequencer
  import cordic_lut_pkg::*;
#(
  parameter int P     = LUT_P,
  parameter int D     = LUT_D,
  parameter int FIRST = 0,
  parameter int LAST  = 31
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BEGIN,
  output logic         EN_ROM,
  output logic [D-1:0] ADRS,
  input  logic [P-1:0] ROM_D,
  output logic         STEP_VALID,
  input  logic         STEP_READY,
  output logic [P-1:0] STEP_DATA,
  output logic [D-1:0] STEP_IDX,
  output logic         STEP_LAST,
  output logic         BUSY,
  output logic         DONE
);

  localparam logic [D-1:0] c_first = D'(FIRST);
  localparam logic [D-1:0] c_last  = D'(LAST);
  localparam logic [D-1:0] c_one   = D'(1);

  seq_state_t   r_state, w_state_nxt;
  logic [D-1:0] r_idx, w_idx_nxt;
  logic [D-1:0] r_adrs, w_adrs_nxt;
  logic [P-1:0] r_data, w_data_nxt;
  logic [D-1:0] r_step_idx, w_step_idx_nxt;
  logic         r_step_last, w_step_last_nxt;
  logic [D-1:0] w_idx_inc;
  logic         w_is_last;
  logic         w_accept;
`ifdef LUT_SEQ_PREFETCH_EN
  logic         r_first_hold, w_first_hold_nxt;
`endif

  assign w_idx_inc = r_idx + c_one;
  assign w_is_last = (r_idx == c_last);
  assign w_accept  = (r_state == ST_HOLD) && STEP_READY;

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_adrs_nxt      = r_adrs;
    w_data_nxt      = r_data;
    w_step_idx_nxt  = r_step_idx;
    w_step_last_nxt = r_step_last;
`ifdef LUT_SEQ_PREFETCH_EN
    w_first_hold_nxt = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (BEGIN) begin
          w_state_nxt = ST_ISSUE;
          w_idx_nxt   = c_first;
          w_adrs_nxt  = c_first;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        w_data_nxt      = ROM_D;
        w_step_idx_nxt  = r_idx;
        w_step_last_nxt = w_is_last;
        w_state_nxt     = ST_HOLD;
`ifdef LUT_SEQ_PREFETCH_EN
        w_first_hold_nxt = 1'b1;
        if (!w_is_last) w_adrs_nxt = w_idx_inc;
`endif
      end
      ST_HOLD: begin
        if (w_accept) begin
          if (w_is_last) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_idx_nxt = w_idx_inc;
`ifdef LUT_SEQ_PREFETCH_EN
            // Prefetched word is only on ROM_D once a cycle has passed since the issue
            if (r_first_hold) begin
              w_state_nxt = ST_WAIT;
            end else begin
              w_data_nxt       = ROM_D;
              w_step_idx_nxt   = w_idx_inc;
              w_step_last_nxt  = (w_idx_inc == c_last);
              w_first_hold_nxt = 1'b1;
              if (w_idx_inc != c_last) w_adrs_nxt = w_idx_inc + c_one;
            end
`else
            w_state_nxt = ST_ISSUE;
            w_adrs_nxt  = w_idx_inc;
`endif
          end
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_adrs      <= '0;
      r_data      <= '0;
      r_step_idx  <= '0;
      r_step_last <= 1'b0;
`ifdef LUT_SEQ_PREFETCH_EN
      r_first_hold <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_adrs      <= w_adrs_nxt;
      r_data      <= w_data_nxt;
      r_step_idx  <= w_step_idx_nxt;
      r_step_last <= w_step_last_nxt;
`ifdef LUT_SEQ_PREFETCH_EN
      r_first_hold <= w_first_hold_nxt;
`endif
    end
  end

`ifdef LUT_SEQ_PREFETCH_EN
  assign EN_ROM = (r_state == ST_ISSUE) ||
                  ((r_state == ST_HOLD) && r_first_hold && !w_is_last);
`else
  assign EN_ROM = (r_state == ST_ISSUE);
`endif
  assign ADRS       = r_adrs;
  assign STEP_VALID = (r_state == ST_HOLD);
  assign STEP_DATA  = r_data;
  assign STEP_IDX   = r_step_idx;
  assign STEP_LAST  = r_step_last;
  assign BUSY       = (r_state != ST_IDLE);
  assign DONE       = (r_state == ST_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_lut_shift_sequencer.sv
`default_nettype none
// Scoreboard bench for lut_shift_sequencer: full sweeps, backpressure, ignored
// BEGIN, asynchronous reset mid-sweep and a single-index instance.
module tb_lut_shift_sequencer;
  import cordic_lut_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } step_t;

`ifdef LUT_SEQ_PREFETCH_EN
  localparam int EXP_DONE       = 66;
  localparam int EXP_DONE_STALL = 70;
  localparam int EXP_PF11       = 1;
`else
  localparam int EXP_DONE       = 97;
  localparam int EXP_DONE_STALL = 102;
  localparam int EXP_PF11       = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BEGIN = 1'b0;
  logic        STEP_READY = 1'b1;
  logic        EN_ROM, STEP_VALID, STEP_LAST, BUSY, DONE;
  logic [4:0]  ADRS, STEP_IDX;
  logic [31:0] ROM_D = '0, STEP_DATA;

  logic        BEGIN23 = 1'b0;
  logic        EN_ROM23, STEP_VALID23, STEP_LAST23, BUSY23, DONE23;
  logic [4:0]  ADRS23, STEP_IDX23;
  logic [31:0] ROM_D23 = '0, STEP_DATA23;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt[32];
  int en23 = 0;
  step_t sb_q[$];
  step_t sb23_q[$];
  logic [4:0] adrs_q[$];

  lut_shift_sequencer dut (
    .CLK(CLK), .RST(RST), .BEGIN(BEGIN), .EN_ROM(EN_ROM), .ADRS(ADRS), .ROM_D(ROM_D),
    .STEP_VALID(STEP_VALID), .STEP_READY(STEP_READY), .STEP_DATA(STEP_DATA),
    .STEP_IDX(STEP_IDX), .STEP_LAST(STEP_LAST), .BUSY(BUSY), .DONE(DONE)
  );

  lut_shift_sequencer #(.FIRST(23), .LAST(23)) dut23 (
    .CLK(CLK), .RST(RST), .BEGIN(BEGIN23), .EN_ROM(EN_ROM23), .ADRS(ADRS23), .ROM_D(ROM_D23),
    .STEP_VALID(STEP_VALID23), .STEP_READY(1'b1), .STEP_DATA(STEP_DATA23),
    .STEP_IDX(STEP_IDX23), .STEP_LAST(STEP_LAST23), .BUSY(BUSY23), .DONE(DONE23)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input int i);
    case (i)
      0:       return LUT_W_IDX0;
      7:       return LUT_W_IDX7;
      10:      return 32'h3D800000;
      23:      return 32'h387FFFFE;
      31:      return LUT_W_IDX31;
      default: return 32'h3E000000 + 32'(i) * 32'h00011111;
    endcase
  endfunction

  function automatic step_t mk_step(input int i, input bit last);
    step_t s;
    s.data = rom_word(i);
    s.idx  = 5'(i);
    s.last = last;
    return s;
  endfunction

  // Registered behavioural ROMs: output updates only on an enabled read
  always @(posedge CLK) if (EN_ROM)   ROM_D   <= rom_word(int'(ADRS));
  always @(posedge CLK) if (EN_ROM23) ROM_D23 <= rom_word(int'(ADRS23));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  initial begin : mon_main
    step_t e;
    for (int i = 0; i < 32; i++) en_cnt[i] = 0;
    forever begin
      @(negedge CLK); #1;
      if (STEP_VALID && STEP_READY) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL step_unexpected: actual idx %0d required no step", STEP_IDX);
        end else begin
          e = sb_q.pop_front();
          chk("step_data", STEP_DATA, e.data);
          chk("step_idx", STEP_IDX, e.idx);
          chk("step_last", STEP_LAST, e.last);
        end
      end
      if (EN_ROM) begin
        en_cnt[ADRS]++;
        if (adrs_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL adrs_unexpected: actual %0d required no read", ADRS);
        end else begin
          chk("adrs", ADRS, adrs_q.pop_front());
        end
      end
    end
  end

  initial begin : mon_23
    step_t e;
    forever begin
      @(negedge CLK); #1;
      if (STEP_VALID23) begin
        if (sb23_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL step23_unexpected: actual idx %0d required no step", STEP_IDX23);
        end else begin
          e = sb23_q.pop_front();
          chk("step23_data", STEP_DATA23, e.data);
          chk("step23_idx", STEP_IDX23, e.idx);
          chk("step23_last", STEP_LAST23, e.last);
        end
      end
      if (EN_ROM23) begin
        en23++;
        chk("adrs23", ADRS23, 64'd23);
      end
    end
  end

  // mode 0 plain, 1 stall at idx 10, 2 BEGIN in HOLD/FINISH, 3 reset at idx 12, 4 ready 1,0,0,1
  task automatic run_sweep(input int mode, input int exp_done);
    int c0, stall, base[32], bad;
    bit seen_done, injected;
    for (int i = 0; i < 32; i++) begin
      sb_q.push_back(mk_step(i, i == 31));
      adrs_q.push_back(5'(i));
      base[i] = en_cnt[i];
    end
    stall = 0; seen_done = 0; injected = 0;
    @(negedge CLK);
    BEGIN = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 400 && !seen_done; n++) begin
      @(negedge CLK);
      BEGIN = 1'b0;
      if (n == 0) chk("issue_first_cycle", {BUSY, EN_ROM, ADRS}, {1'b1, 1'b1, 5'd0});
      if (mode == 1) begin
        if (STEP_VALID && STEP_IDX == 5'd10 && stall < 5) begin
          STEP_READY = 1'b0;
          stall++;
          chk("stall_data_stable", STEP_DATA, 32'h3D800000);
        end else begin
          if (STEP_VALID && STEP_IDX == 5'd10) begin
            chk("en_cnt_idx10", en_cnt[10] - base[10], 1);
            chk("en_cnt_idx11_pre_accept", en_cnt[11] - base[11], EXP_PF11);
          end
          STEP_READY = 1'b1;
        end
      end
      if (mode == 2 && !injected && STEP_VALID && STEP_IDX == 5'd5) begin
        BEGIN = 1'b1;
        injected = 1;
      end
      if (mode == 3 && STEP_VALID && STEP_IDX == 5'd12) begin
        RST = 1'b1;
        #1;
        chk("reset_async_outputs",
            {EN_ROM, ADRS, STEP_VALID, STEP_DATA, STEP_IDX, STEP_LAST, BUSY, DONE}, 64'd0);
        sb_q.delete();
        adrs_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        return;
      end
      if (mode == 4) STEP_READY = (n % 4 == 0) || (n % 4 == 3);
      if (DONE) begin
        seen_done = 1;
        if (exp_done >= 0) chk("done_cycle", cyc - c0, exp_done);
        if (mode == 2) BEGIN = 1'b1;
      end
    end
    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL done_timeout: actual no DONE required DONE within 400 cycles");
    end
    @(negedge CLK);
    BEGIN = 1'b0;
    STEP_READY = 1'b1;
    chk("busy_low_after_done", {BUSY, DONE}, 2'b00);
    @(negedge CLK);
    chk("idle_stays_idle", {BUSY, EN_ROM}, 2'b00);
    bad = 0;
    for (int i = 0; i < 32; i++) if (en_cnt[i] - base[i] != 1) bad++;
    chk("en_once_per_idx", bad, 0);
  endtask

  initial begin : main
    int c0;
    bit seen;
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_outputs",
        {EN_ROM, ADRS, STEP_VALID, STEP_DATA, STEP_IDX, STEP_LAST, BUSY, DONE}, 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    run_sweep(0, EXP_DONE);
    run_sweep(1, EXP_DONE_STALL);
    run_sweep(2, EXP_DONE);
    run_sweep(3, -1);
    run_sweep(0, EXP_DONE);
    run_sweep(4, -1);

    sb23_q.push_back(mk_step(23, 1'b1));
    seen = 0;
    @(negedge CLK);
    BEGIN23 = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      BEGIN23 = 1'b0;
      if (DONE23) begin
        seen = 1;
        chk("done23_cycle", cyc - c0, 4);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done23_timeout: actual no DONE required DONE within 20 cycles");
    end
    @(negedge CLK);
    chk("busy23_low", BUSY23, 1'b0);
    chk("en23_once", en23, 1);

    repeat (3) @(negedge CLK);
    chk("sb_drain", sb_q.size(), 0);
    chk("sb23_drain", sb23_q.size(), 0);
    chk("adrs_drain", adrs_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
